// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the unified I/D memory arbiter.
// Owner encodings tag which port the RAM response in flight belongs to.
package mem_arbiter_pkg;

  localparam int DATA_W           = 32;
  localparam int DEF_ADDR_W       = 10;
  localparam int DEF_MAX_D_STREAK = 4;

  typedef logic [DATA_W-1:0] word_t;

  localparam logic [1:0] OWNER_NONE = 2'd0;
  localparam logic [1:0] OWNER_I    = 2'd1;
  localparam logic [1:0] OWNER_D    = 2'd2;

endpackage

// File: rtl/mem_arbiter_if.sv
// CPU fetch/data request ports plus the shared RAM port, as seen by the arbiter (slave)
// and by the CPU/RAM side that drives it (master).
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
);
  logic              i_req;
  logic [31:0]       i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  word_t             i_rdata;

  logic              d_req;
  logic              d_we;
  logic [31:0]       d_addr;
  word_t             d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  word_t             d_rdata;

  logic              m_en;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  word_t             m_wdata;
  word_t             m_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           m_en, m_we, m_addr, m_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           m_en, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/mem_arbiter_streak_cnt.sv
// Saturating count of consecutive data-port wins while fetch is waiting.
// clr has priority over inc; sat flags the count has reached MAX.
module arb_streak_cnt #(
  parameter int MAX = 4,
  parameter int W   = (MAX < 1) ? 1 : $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         sat
);
  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != MAX_V)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign sat = (cnt_q == MAX_V);
endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port RAM between instruction fetch and data ports; data wins
// unless fetch has lost MAX_D_STREAK times in a row. One grant per cycle, 1-cycle response.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int MAX_D_STREAK = DEF_MAX_D_STREAK
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);
  localparam int SW = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);

  logic          i_win, d_win;
  logic          streak_sat;
  logic [SW-1:0] streak_cnt;
  logic [1:0]    owner_d, owner_q;
  logic          d_we_d, d_we_q;

  // Grants are suppressed during reset so nothing issued then can produce a response.
  always_comb begin
    i_win = 1'b0;
    d_win = 1'b0;
    if (rst) begin
      if (bus.d_req && !(bus.i_req && streak_sat)) begin
        d_win = 1'b1;
      end else if (bus.i_req) begin
        i_win = 1'b1;
      end
    end
  end

  assign bus.i_gnt   = i_win;
  assign bus.d_gnt   = d_win;
  assign bus.m_en    = i_win | d_win;
  assign bus.m_we    = d_win & bus.d_we;
  assign bus.m_addr  = d_win ? bus.d_addr[ADDR_W+1:2] :
                       i_win ? bus.i_addr[ADDR_W+1:2] : '0;
  assign bus.m_wdata = d_win ? bus.d_wdata : '0;

  always_comb begin
    owner_d = OWNER_NONE;
    d_we_d  = 1'b0;
    if (i_win) begin
      owner_d = OWNER_I;
    end else if (d_win) begin
      owner_d = OWNER_D;
      d_we_d  = bus.d_we;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      owner_q <= OWNER_NONE;
      d_we_q  <= 1'b0;
    end else begin
      owner_q <= owner_d;
      d_we_q  <= d_we_d;
    end
  end

  arb_streak_cnt #(.MAX(MAX_D_STREAK), .W(SW)) u_streak (
    .clk (clk),
    .rst (rst),
    .clr (i_win | ~bus.i_req),
    .inc (d_win & bus.i_req),
    .cnt (streak_cnt),
    .sat (streak_sat)
  );

  // Writes are acknowledged with zero data rather than the RAM's stale read word.
  assign bus.i_rvalid = rst && (owner_q == OWNER_I);
  assign bus.d_rvalid = rst && (owner_q == OWNER_D);
  assign bus.i_rdata  = bus.i_rvalid ? bus.m_rdata : '0;
  assign bus.d_rdata  = (bus.d_rvalid && !d_we_q) ? bus.m_rdata : '0;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.i_addr[31:ADDR_W+2], bus.i_addr[1:0],
                              bus.d_addr[31:ADDR_W+2], bus.d_addr[1:0], streak_cnt};
endmodule
